// File: rtl/rv32_mem_stage.sv
// rv32_mem_stage: pipeline memory stage driving a req/gnt/rvalid data bus,
// aligning load data, generating store byte enables and registering the writeback entry.
package rv32_mem_pkg;
  localparam logic [31:0] RV_NOP = 32'h0000_0013;
  typedef enum logic [3:0] {
    MEM_NONE, MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU, MEM_SB, MEM_SH, MEM_SW
  } mem_op_e;
  typedef struct packed {
    mem_op_e    mem_op;
    logic       reg_write;
    logic [4:0] rd;
  } decoded_instr_t;
  typedef struct packed {
    logic [31:0]    instr;
    logic [31:0]    pc;
    decoded_instr_t decoded_instr;
    logic [31:0]    mem_addr;
    logic [31:0]    wb_result;
  } exec_mem_buffer_t;
  typedef struct packed {
    logic [31:0]    instr;
    logic [31:0]    pc;
    decoded_instr_t decoded_instr;
    logic [31:0]    wb_result;
  } mem_wb_buffer_t;
  function automatic decoded_instr_t create_nop_ctrl();
    create_nop_ctrl = '{mem_op: MEM_NONE, reg_write: 1'b0, rd: 5'd0};
  endfunction
endpackage

module rv32_mem_stage
  import rv32_mem_pkg::*;
#(
  parameter int unsigned RESP_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  exec_mem_buffer_t exec_mem_buff,
  input  logic             stop,
  output mem_wb_buffer_t   mem_wb_buff,
  output logic             mem_stall,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [3:0]       dmem_be,
  output logic [31:0]      dmem_addr,
  output logic [31:0]      dmem_wdata,
  input  logic             dmem_gnt,
  input  logic             dmem_rvalid,
  input  logic [31:0]      dmem_rdata,
  output logic             misaligned,
  output logic             bus_error
);
  localparam logic [1:0] IDLE = 2'd0, WAIT_RESP = 2'd1, DONE = 2'd2;
  localparam mem_wb_buffer_t NOP_WB = '{instr: RV_NOP, pc: 32'd0, decoded_instr: create_nop_ctrl(), wb_result: 32'd0};
  logic [1:0]     state_q, state_d;
  logic [31:0]    cnt_q, cnt_d;
  mem_wb_buffer_t res_q, res_d, mem_wb_q;
  logic           res_err_q, res_err_d, mis_q, berr_q;
  mem_op_e        op;
  logic [1:0]     off;
  logic [31:0]    wb_in, shifted, load_val;
  logic           is_b, is_h, is_w, is_store, mis, go, timeout;
  assign op       = exec_mem_buff.decoded_instr.mem_op;
  assign off      = exec_mem_buff.mem_addr[1:0];
  assign wb_in    = exec_mem_buff.wb_result;
  assign is_b     = op inside {MEM_LB, MEM_LBU, MEM_SB};
  assign is_h     = op inside {MEM_LH, MEM_LHU, MEM_SH};
  assign is_w     = op inside {MEM_LW, MEM_SW};
  assign is_store = op inside {MEM_SB, MEM_SH, MEM_SW};
  assign mis      = (is_h && off[0]) || (is_w && off != 2'd0);
  assign go       = (is_b || is_h || is_w) && !mis;
  assign dmem_req   = state_q == IDLE && go;
  assign mem_stall  = dmem_req || state_q == WAIT_RESP;
  assign dmem_we    = is_store;
  assign dmem_addr  = {exec_mem_buff.mem_addr[31:2], 2'b00};
  assign dmem_be    = is_b ? 4'b0001 << off : is_h ? (off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign dmem_wdata = is_b ? {4{wb_in[7:0]}} : is_h ? {2{wb_in[15:0]}} : wb_in;
  assign shifted  = dmem_rdata >> {off, 3'b000};
  assign load_val = op == MEM_LB  ? {{24{shifted[7]}}, shifted[7:0]} :
                    op == MEM_LH  ? {{16{shifted[15]}}, shifted[15:0]} :
                    op == MEM_LBU ? {24'd0, shifted[7:0]} :
                    op == MEM_LHU ? {16'd0, shifted[15:0]} : dmem_rdata;
  // cnt_q counts completed WAIT_RESP cycles, so this fires on the RESP_TIMEOUT-th silent cycle
  assign timeout  = RESP_TIMEOUT != 0 && cnt_q + 32'd1 == 32'(RESP_TIMEOUT);
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    res_d     = res_q;
    res_err_d = res_err_q;
    if (state_q == IDLE) begin
      state_d = go && dmem_gnt ? WAIT_RESP : IDLE;
      cnt_d   = 32'd0;
    end else if (state_q == WAIT_RESP) begin
      cnt_d = cnt_q + 32'd1;
      if (dmem_rvalid || timeout) begin
        state_d   = DONE;
        res_err_d = !dmem_rvalid;
        res_d     = '{instr: exec_mem_buff.instr, pc: exec_mem_buff.pc,
                      decoded_instr: dmem_rvalid ? exec_mem_buff.decoded_instr : create_nop_ctrl(),
                      wb_result: dmem_rvalid && !is_store ? load_val : wb_in};
      end
    end else begin
      state_d = stop ? DONE : IDLE;
      cnt_d   = 32'd0;
    end
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= IDLE;
      cnt_q     <= 32'd0;
      res_q     <= NOP_WB;
      res_err_q <= 1'b0;
      mem_wb_q  <= NOP_WB;
      mis_q     <= 1'b0;
      berr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      res_q     <= res_d;
      res_err_q <= res_err_d;
      if (state_q == IDLE && !go && !stop) begin
        mem_wb_q <= '{instr: exec_mem_buff.instr, pc: exec_mem_buff.pc,
                      decoded_instr: mis ? create_nop_ctrl() : exec_mem_buff.decoded_instr,
                      wb_result: wb_in};
        mis_q    <= mis;
        berr_q   <= 1'b0;
      end else if (state_q == DONE && !stop) begin
        mem_wb_q <= res_q;
        mis_q    <= 1'b0;
        berr_q   <= res_err_q;
      end
    end
  end
  assign mem_wb_buff = mem_wb_q;
  assign misaligned  = mis_q;
  assign bus_error   = berr_q;
endmodule
